align_shift: RTL and testbench

- Pipelined alignment stage of the floating-point adder. Sits directly downstream of the operand swap stage.
- Takes the swapped operands (larger-exponent operand A, smaller-exponent operand B with guard/round extension) and the exponent difference.
- Right-shifts B's extended fraction by that difference and produces a sticky bit, feeding the significand add/sub stage.
- Three-cycle pipeline with a valid/ready handshake and a global stall.

---
 rtl/align_shift.sv | 114 +++++++++++
 tb/tb_align_shift.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/align_shift.sv
// Alignment stage of the FP adder: right-shifts B's guard/round-extended significand
// by the exponent difference over three pipelined shift steps and collects a sticky bit.
module align_shift #(
  parameter int FW = 53,
  parameter int EW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          sa2,
  input  logic [FW-1:0] fa2,
  input  logic          sb2,
  input  logic [FW+1:0] fb2,
  input  logic [EW-1:0] e_max,
  input  logic [EW-1:0] shamt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          sa_o,
  output logic [FW-1:0] fa_o,
  output logic          sb_o,
  output logic [FW+1:0] fb_al,
  output logic          sticky,
  output logic [EW-1:0] e_o
);

  localparam int XW = FW + 2;
  localparam logic [EW-1:0] SH_MAX = EW'(FW + 3);
  localparam logic [5:0] EFF_MAX = 6'(FW + 3);

  // Any shift of FW+3 or more clears the whole field, so clamp instead of wrapping.
  function automatic logic [5:0] clamp_shamt(input logic [EW-1:0] s);
    if (s >= SH_MAX) return EFF_MAX;
    else return s[5:0];
  endfunction

  // Returns {sticky, shifted}: sticky is the OR of every bit dropped below bit 0.
  function automatic logic [XW:0] shr_sticky(input logic [XW-1:0] v, input logic [5:0] s);
    logic [XW-1:0] lost;
    lost = v & ~({XW{1'b1}} << s);
    return {|lost, v >> s};
  endfunction

  logic          advance;
  logic [5:0]    eff_in;
  logic [XW:0]   sh_0, sh_1, sh_2;

  logic          vld_p0, vld_p1, vld_p2;
  logic          sa_p0, sa_p1, sa_p2;
  logic          sb_p0, sb_p1, sb_p2;
  logic [FW-1:0] fa_p0, fa_p1, fa_p2;
  logic [EW-1:0] e_p0, e_p1, e_p2;
  logic [XW-1:0] fb_p0, fb_p1, fb_p2;
  logic          stk_p0, stk_p1, stk_p2;
  logic [3:0]    eff_p0;
  logic [1:0]    eff_p1;

  assign advance  = ~vld_p2 | out_ready;
  assign in_ready = advance;

  assign eff_in = clamp_shamt(shamt);
  assign sh_0   = shr_sticky(fb2, {eff_in[5:4], 4'b0000});
  assign sh_1   = shr_sticky(fb_p0, {2'b00, eff_p0[3:2], 2'b00});
  assign sh_2   = shr_sticky(fb_p1, {4'b0000, eff_p1});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0; vld_p1 <= 1'b0; vld_p2 <= 1'b0;
      sa_p0  <= 1'b0; sa_p1  <= 1'b0; sa_p2  <= 1'b0;
      sb_p0  <= 1'b0; sb_p1  <= 1'b0; sb_p2  <= 1'b0;
      fa_p0  <= '0;   fa_p1  <= '0;   fa_p2  <= '0;
      e_p0   <= '0;   e_p1   <= '0;   e_p2   <= '0;
      fb_p0  <= '0;   fb_p1  <= '0;   fb_p2  <= '0;
      stk_p0 <= 1'b0; stk_p1 <= 1'b0; stk_p2 <= 1'b0;
      eff_p0 <= '0;   eff_p1 <= '0;
    end else if (advance) begin
      // Stage 1: capture operands, coarse shift by multiples of 16
      vld_p0 <= in_valid & in_ready;
      sa_p0  <= sa2;
      sb_p0  <= sb2;
      fa_p0  <= fa2;
      e_p0   <= e_max;
      fb_p0  <= sh_0[XW-1:0];
      stk_p0 <= sh_0[XW];
      eff_p0 <= eff_in[3:0];
      // Stage 2: shift by multiples of 4
      vld_p1 <= vld_p0;
      sa_p1  <= sa_p0;
      sb_p1  <= sb_p0;
      fa_p1  <= fa_p0;
      e_p1   <= e_p0;
      fb_p1  <= sh_1[XW-1:0];
      stk_p1 <= stk_p0 | sh_1[XW];
      eff_p1 <= eff_p0[1:0];
      // Stage 3: final 0..3 shift, drives the outputs
      vld_p2 <= vld_p1;
      sa_p2  <= sa_p1;
      sb_p2  <= sb_p1;
      fa_p2  <= fa_p1;
      e_p2   <= e_p1;
      fb_p2  <= sh_2[XW-1:0];
      stk_p2 <= stk_p1 | sh_2[XW];
    end
  end

  assign out_valid = vld_p2;
  assign sa_o      = sa_p2;
  assign fa_o      = fa_p2;
  assign sb_o      = sb_p2;
  assign fb_al     = fb_p2;
  assign sticky    = stk_p2;
  assign e_o       = e_p2;

endmodule

// File: tb/tb_align_shift.sv
// Scoreboard bench for align_shift: a driver pushes model results on each accepted
// set, and a negedge monitor pops and compares on every output transfer.
module tb_align_shift;

  localparam int FW = 53;
  localparam int EW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic          sa2, sb2;
  logic [FW-1:0] fa2;
  logic [FW+1:0] fb2;
  logic [EW-1:0] e_max, shamt;
  logic          out_valid, out_ready;
  logic          sa_o, sb_o, sticky;
  logic [FW-1:0] fa_o;
  logic [FW+1:0] fb_al;
  logic [EW-1:0] e_o;

  align_shift #(.FW(FW), .EW(EW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .sa2(sa2), .fa2(fa2), .sb2(sb2), .fb2(fb2), .e_max(e_max), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready),
    .sa_o(sa_o), .fa_o(fa_o), .sb_o(sb_o), .fb_al(fb_al), .sticky(sticky), .e_o(e_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          sa;
    logic [FW-1:0] fa;
    logic          sb;
    logic [FW+1:0] fb;
    logic          stk;
    logic [EW-1:0] e;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   rand_ready = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: plain arithmetic shift; sticky set when shifting back does not restore fb2.
  function automatic exp_t model(input logic sa, input logic [FW-1:0] fa, input logic sb,
                                 input logic [FW+1:0] fb, input logic [EW-1:0] e,
                                 input logic [EW-1:0] sh);
    exp_t x;
    logic [FW+1:0] back;
    x.sa = sa; x.fa = fa; x.sb = sb; x.e = e;
    x.fb = fb >> sh;
    back = x.fb << sh;
    x.stk = (back != fb);
    return x;
  endfunction

  task automatic send(input logic sa, input logic [FW-1:0] fa, input logic sb,
                      input logic [FW+1:0] fb, input logic [EW-1:0] e, input logic [EW-1:0] sh);
    bit acc = 0;
    int guard = 0;
    in_valid = 1'b1; sa2 = sa; fa2 = fa; sb2 = sb; fb2 = fb; e_max = e; shamt = sh;
    while (!acc) begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      guard++;
      if (!acc && guard > 1000) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    if (acc) sb_q.push_back(model(sa, fa, sb, fb, e, sh));
    in_valid = 1'b0;
  endtask

  task automatic send_rand_pass(input logic [FW+1:0] fb, input logic [EW-1:0] sh);
    logic [63:0] r;
    r = {$urandom, $urandom};
    send(r[0], r[FW:1], r[FW+1], fb, EW'($urandom), sh);
  endtask

  task automatic lat_check(input string nm);
    @(negedge clk); chk({nm, "_lat1"}, out_valid, 0);
    @(negedge clk); chk({nm, "_lat2"}, out_valid, 0);
    @(negedge clk); chk({nm, "_lat3"}, out_valid, 1);
  endtask

  task automatic drain();
    int g = 0;
    out_ready = 1'b1;
    while (sb_q.size() != 0 && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    chk("drain", sb_q.size(), 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // Monitor: scoreboard compare on output transfers, plus hold-stability during stalls.
  logic          hold = 1'b0;
  logic [127:0]  h_pass, h_fb;
  always @(negedge clk) begin
    if (!rst) begin
      if (hold) begin
        chk("stall_hold_fb", {out_valid, fb_al, sticky}, h_fb);
        chk("stall_hold_pass", {sa_o, fa_o, sb_o, e_o}, h_pass);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 0);
        end else begin
          exp_t x;
          x = sb_q.pop_front();
          chk("fb_al", fb_al, x.fb);
          chk("sticky", sticky, x.stk);
          chk("sa_o", sa_o, x.sa);
          chk("fa_o", fa_o, x.fa);
          chk("sb_o", sb_o, x.sb);
          chk("e_o", e_o, x.e);
        end
      end
      hold   = out_valid && !out_ready;
      h_fb   = {out_valid, fb_al, sticky};
      h_pass = {sa_o, fa_o, sb_o, e_o};
    end else begin
      hold = 1'b0;
    end
  end

  initial begin
    logic [63:0] r;
    logic [FW+1:0] fb;
    logic [EW-1:0] sh;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    sa2 = 1'b0; sb2 = 1'b0; fa2 = '0; fb2 = '0; e_max = '0; shamt = '0;
    repeat (3) begin @(posedge clk); #1; end
    chk("reset_out_valid", out_valid, 0);
    chk("reset_data", {sa_o, fa_o, sb_o, fb_al, sticky, e_o}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", in_ready, 1);

    // Single set, exact latency and explicit value
    send(1'b1, 53'h1_2345_6789_abcd, 1'b0, 55'h40000000000000, 11'h3ff, 11'd1);
    lat_check("t1");
    chk("t1_fb_al", fb_al, 55'h20000000000000);
    chk("t1_sticky", sticky, 0);
    drain();

    // Large shifts back to back, including clamp and non-wrap at 64
    send_rand_pass(55'h40000000000000, 11'd54);
    send_rand_pass(55'h40000000000000, 11'd55);
    send_rand_pass(55'h40000000000000, 11'd2047);
    send_rand_pass(55'h40000000000000, 11'd64);
    repeat (3) begin @(negedge clk); chk("t2_back_to_back", out_valid, 1); end
    drain();

    // Small shifts and zero shift
    send_rand_pass(55'h7, 11'd2);
    send_rand_pass(55'h4, 11'd2);
    send_rand_pass(55'h5A, 11'd0);
    drain();

    // Stall of 4 cycles after the first output
    fork
      begin
        for (int i = 0; i < 5; i++) send_rand_pass(55'h1234_5678_9abc_d + 55'(i), 11'(i * 7));
      end
      begin
        int g = 0;
        do begin @(negedge clk); g++; end while (!out_valid && g < 50);
        chk("stall_first_out", out_valid, 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 0);
          chk("stall_out_valid", out_valid, 1);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with three sets in flight
    send_rand_pass(55'h7ff, 11'd3);
    send_rand_pass(55'h7fe, 11'd4);
    send_rand_pass(55'h7fd, 11'd5);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_data", {sa_o, fa_o, sb_o, fb_al, sticky, e_o}, 0);
    sb_q.delete();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);
    send_rand_pass(55'h00ff_00ff_00ff, 11'd8);
    lat_check("t5");
    drain();
    repeat (5) begin @(negedge clk); chk("no_stale_out", out_valid, 0); end
    @(posedge clk); #1;

    // Randomized sets with random backpressure
    rand_ready = 1;
    for (int i = 0; i < 10000; i++) begin
      r = {$urandom, $urandom};
      fb = r[FW+1:0];
      if ($urandom_range(0, 3) == 0) fb = fb & ({(FW+2){1'b1}} << $urandom_range(0, 56));
      sh = ($urandom_range(0, 1) != 0) ? EW'($urandom_range(0, 63)) : EW'($urandom_range(0, 2047));
      send_rand_pass(fb, sh);
    end
    rand_ready = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
